// File: rtl/vga_text_timing.sv
// Video timing and text-readout address generator. Raster counters, registered cell and VRAM
// address outputs, and a configurable delay line that lines the sync/blank outputs up with the pixel pipeline.
module vga_text_timing #(
   parameter int H_VIS      = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VIS      = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int CELL_W     = 8,
   parameter int CELL_H     = 16,
   parameter int COLS       = 80,
   parameter int BPC        = 2,
   parameter int ADDR_W     = 13,
   parameter int PIPE_DELAY = 2
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic [ADDR_W-1:0]           startAddr,
   output logic [ADDR_W-1:0]           readoutAddr,
   output logic [$clog2(CELL_W)-1:0]   cellX,
   output logic [$clog2(CELL_H)-1:0]   cellY,
   output logic                        active,
   output logic                        lineStart,
   output logic                        frameStart,
   output logic                        hSync,
   output logic                        vSync,
   output logic                        nVis
);

   localparam int HTOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);
   localparam int CXW    = $clog2(CELL_W);
   localparam int CYW    = $clog2(CELL_H);

   localparam logic [ADDR_W-1:0] BPC_STEP = ADDR_W'(BPC);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS * BPC);
   localparam logic HS_ON  = (H_SYNC_POL != 0);
   localparam logic HS_OFF = ~HS_ON;
   localparam logic VS_ON  = (V_SYNC_POL != 0);
   localparam logic VS_OFF = ~VS_ON;

   logic [HW-1:0]         h_cnt;
   logic [VW-1:0]         v_cnt;
   logic [ADDR_W-1:0]     row_base;
   logic                  h_vis, v_vis, vis;
   logic                  h_last, v_last;
   logic                  hs_now, vs_now;
   logic [PIPE_DELAY:0]   hs_dly, vs_dly, nv_dly;

   always_comb begin
      h_vis  = int'(h_cnt) < H_VIS;
      v_vis  = int'(v_cnt) < V_VIS;
      vis    = h_vis && v_vis;
      h_last = int'(h_cnt) == HTOTAL - 1;
      v_last = int'(v_cnt) == VTOTAL - 1;
      hs_now = (int'(h_cnt) >= H_VIS + H_FP && int'(h_cnt) < H_VIS + H_FP + H_SYNC) ? HS_ON : HS_OFF;
      vs_now = (int'(v_cnt) >= V_VIS + V_FP && int'(v_cnt) < V_VIS + V_FP + V_SYNC) ? VS_ON : VS_OFF;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // row_base doubles as the start-address latch: it is loaded straight from startAddr on the
   // last pixel of the frame, so the new frame's first cell reads from the freshly sampled address.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         row_base <= '0;
      end else if (h_last && v_last) begin
         row_base <= startAddr;
      end else if (h_last && v_vis && (&v_cnt[CYW-1:0])) begin
         row_base <= row_base + ROW_STEP;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         readoutAddr <= '0;
         cellX       <= '0;
         cellY       <= '0;
         active      <= 1'b0;
         lineStart   <= 1'b0;
         frameStart  <= 1'b0;
      end else begin
         if (vis) begin
            if (h_cnt == '0)
               readoutAddr <= row_base;
            else if (h_cnt[CXW-1:0] == '0)
               readoutAddr <= readoutAddr + BPC_STEP;
         end
         cellX      <= vis ? h_cnt[CXW-1:0] : '0;
         cellY      <= v_cnt[CYW-1:0];
         active     <= vis;
         lineStart  <= vis && (h_cnt == '0);
         frameStart <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hs_dly <= {(PIPE_DELAY+1){HS_OFF}};
         vs_dly <= {(PIPE_DELAY+1){VS_OFF}};
         nv_dly <= '1;
      end else begin
         hs_dly[0] <= hs_now;
         vs_dly[0] <= vs_now;
         nv_dly[0] <= ~vis;
         for (int i = 1; i <= PIPE_DELAY; i++) begin
            hs_dly[i] <= hs_dly[i-1];
            vs_dly[i] <= vs_dly[i-1];
            nv_dly[i] <= nv_dly[i-1];
         end
      end
   end

   assign hSync = hs_dly[PIPE_DELAY];
   assign vSync = vs_dly[PIPE_DELAY];
   assign nVis  = nv_dly[PIPE_DELAY];

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing on a reduced raster; expected outputs come from raster-coordinate arithmetic.
module tb_vga_text_timing;

   localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
   localparam int V_VIS = 30, V_FP = 2, V_SYNC = 3, V_BP = 3;
   localparam int HPOL = 1, VPOL = 0;
   localparam int CW = 4, CH = 8, COLS = 10, BPC = 2, AW = 8, PD = 3;
   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FT = HT * VT;

   logic          clk = 1'b0;
   logic          nrst;
   logic [AW-1:0] startAddr;
   logic [AW-1:0] readoutAddr;
   logic [1:0]    cellX;
   logic [2:0]    cellY;
   logic          active, lineStart, frameStart, hSync, vSync, nVis;

   int checks = 0;
   int errors = 0;

   // model state: edges since reset release and derived expectations
   int            m_k, m_p, m_h, m_v;
   logic [AW-1:0] m_pending, m_start, m_addr;
   logic [1:0]    e_cx;
   logic [2:0]    e_cy;
   logic          e_active, e_ls, e_fs, e_hs, e_vs, e_nv;

   always #5 clk = ~clk;

   vga_text_timing #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
      .CELL_W(CW), .CELL_H(CH), .COLS(COLS), .BPC(BPC),
      .ADDR_W(AW), .PIPE_DELAY(PD)
   ) dut (
      .clk(clk), .nrst(nrst), .startAddr(startAddr),
      .readoutAddr(readoutAddr), .cellX(cellX), .cellY(cellY),
      .active(active), .lineStart(lineStart), .frameStart(frameStart),
      .hSync(hSync), .vSync(vSync), .nVis(nVis)
   );

   task automatic model_reset();
      m_k = 0; m_p = 0; m_h = 0; m_v = 0;
      m_pending = '0; m_start = '0; m_addr = '0;
   endtask

   // Expected outputs after edge m_k: pixel (m_k-1) of the raster, sync/blank from pixel (m_k-1-PD).
   task automatic model_step();
      int q, pq, hq, vq;
      logic vis;
      m_k++;
      m_p = (m_k - 1) % FT;
      m_h = m_p % HT;
      m_v = m_p / HT;
      if (m_p == 0) m_start = m_pending;
      if (m_p == FT - 1) m_pending = startAddr;
      vis = (m_h < H_VIS) && (m_v < V_VIS);
      e_active = vis;
      e_ls = vis && (m_h == 0);
      e_fs = (m_p == 0);
      e_cx = vis ? 2'(m_h % CW) : 2'd0;
      e_cy = 3'(m_v % CH);
      if (vis) m_addr = AW'(int'(m_start) + (m_v / CH) * COLS * BPC + (m_h / CW) * BPC);
      q = m_k - 1 - PD;
      if (q < 0) begin
         e_hs = !HPOL[0]; e_vs = !VPOL[0]; e_nv = 1'b1;
      end else begin
         pq = q % FT; hq = pq % HT; vq = pq / HT;
         e_hs = (hq >= H_VIS + H_FP && hq < H_VIS + H_FP + H_SYNC) ? HPOL[0] : !HPOL[0];
         e_vs = (vq >= V_VIS + V_FP && vq < V_VIS + V_FP + V_SYNC) ? VPOL[0] : !VPOL[0];
         e_nv = !((hq < H_VIS) && (vq < V_VIS));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      startAddr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (readoutAddr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", readoutAddr); end
      checks++; if (cellX !== 2'd0) begin errors++; $display("FAIL reset_cellx: got %0d want 0", cellX); end
      checks++; if (cellY !== 3'd0) begin errors++; $display("FAIL reset_celly: got %0d want 0", cellY); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++; if (lineStart !== 1'b0) begin errors++; $display("FAIL reset_linestart: got %b want 0", lineStart); end
      checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL reset_framestart: got %b want 0", frameStart); end
      checks++; if (hSync !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b want 0", hSync); end
      checks++; if (vSync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vSync); end
      checks++; if (nVis !== 1'b1) begin errors++; $display("FAIL reset_nvis: got %b want 1", nVis); end
   endtask

   task automatic test_release();
      nrst = 1'b1;
      model_reset();
      tick();
      checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL first_framestart: got %b want 1", frameStart); end
      checks++; if (lineStart !== 1'b1) begin errors++; $display("FAIL first_linestart: got %b want 1", lineStart); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL first_active: got %b want 1", active); end
      checks++; if (readoutAddr !== 8'd0) begin errors++; $display("FAIL first_addr: got %0d want 0", readoutAddr); end
      checks++; if (nVis !== 1'b1) begin errors++; $display("FAIL first_nvis_delayed: got %b want 1", nVis); end
      for (int i = 0; i < PD; i++) tick();
      checks++; if (nVis !== 1'b0) begin errors++; $display("FAIL nvis_latency: got %b want 0", nVis); end
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 2 * FT + 50; i++) begin
         tick();
         checks++; if (readoutAddr !== m_addr) begin errors++; $display("FAIL rnd_addr k=%0d: got %0d want %0d", m_k, readoutAddr, m_addr); end
         checks++; if (cellX !== e_cx) begin errors++; $display("FAIL rnd_cellx k=%0d: got %0d want %0d", m_k, cellX, e_cx); end
         checks++; if (cellY !== e_cy) begin errors++; $display("FAIL rnd_celly k=%0d: got %0d want %0d", m_k, cellY, e_cy); end
         checks++; if (active !== e_active) begin errors++; $display("FAIL rnd_active k=%0d: got %b want %b", m_k, active, e_active); end
         checks++; if (lineStart !== e_ls) begin errors++; $display("FAIL rnd_linestart k=%0d: got %b want %b", m_k, lineStart, e_ls); end
         checks++; if (frameStart !== e_fs) begin errors++; $display("FAIL rnd_framestart k=%0d: got %b want %b", m_k, frameStart, e_fs); end
         checks++; if (hSync !== e_hs) begin errors++; $display("FAIL rnd_hsync k=%0d: got %b want %b", m_k, hSync, e_hs); end
         checks++; if (vSync !== e_vs) begin errors++; $display("FAIL rnd_vsync k=%0d: got %b want %b", m_k, vSync, e_vs); end
         checks++; if (nVis !== e_nv) begin errors++; $display("FAIL rnd_nvis k=%0d: got %b want %b", m_k, nVis, e_nv); end
         if ($urandom_range(0, 40) == 0) startAddr = AW'($urandom);
         if ((i % FT) == FT - 2) startAddr = AW'($urandom_range(200, 255));
      end
   endtask

   task automatic test_sync_counts();
      int hs_on = 0, vs_on = 0, fs = 0, ls = 0, gap = 0;
      bit found = 0;
      for (int i = 0; i < FT; i++) begin
         tick();
         if (hSync === HPOL[0]) hs_on++;
         if (vSync === VPOL[0]) vs_on++;
         if (frameStart === 1'b1) fs++;
         if (lineStart === 1'b1) ls++;
      end
      checks++; if (hs_on != H_SYNC * VT) begin errors++; $display("FAIL hsync_cycles: got %0d want %0d", hs_on, H_SYNC * VT); end
      checks++; if (vs_on != V_SYNC * HT) begin errors++; $display("FAIL vsync_cycles: got %0d want %0d", vs_on, V_SYNC * HT); end
      checks++; if (fs != 1) begin errors++; $display("FAIL framestart_per_frame: got %0d want 1", fs); end
      checks++; if (ls != V_VIS) begin errors++; $display("FAIL linestart_per_frame: got %0d want %0d", ls, V_VIS); end
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick();
         if (frameStart === 1'b1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL framestart_wait: got none want pulse"); end
      found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick();
         gap++;
         if (frameStart === 1'b1) found = 1;
      end
      checks++; if (gap != FT) begin errors++; $display("FAIL frame_period: got %0d want %0d", gap, FT); end
   endtask

   task automatic test_scroll_wrap();
      bit found = 0, seen0 = 0, seen8 = 0, seen24 = 0;
      startAddr = 8'd250;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick();
         if (m_p == FT - 1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL scroll_latch_wait: got none want frame end"); end
      startAddr = 8'd5;
      found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick();
         if (m_p == 0) begin
            seen0 = 1;
            checks++; if (readoutAddr !== 8'd250) begin errors++; $display("FAIL scroll_row0: got %0d want 250", readoutAddr); end
         end
         if (m_v == 8 && m_h == 0) begin
            seen8 = 1;
            checks++; if (readoutAddr !== 8'd14) begin errors++; $display("FAIL scroll_row1_wrap: got %0d want 14", readoutAddr); end
         end
         if (m_v == 24 && m_h == 36) begin
            seen24 = 1; found = 1;
            checks++; if (readoutAddr !== 8'd72) begin errors++; $display("FAIL scroll_row3_last: got %0d want 72", readoutAddr); end
         end
         if (m_v == 24 && m_h == 39 && readoutAddr !== 8'd72) begin
            errors++; $display("FAIL scroll_hold: got %0d want 72", readoutAddr);
         end
      end
      checks++; if (!(seen0 && seen8 && seen24)) begin errors++; $display("FAIL scroll_points: got %b%b%b want 111", seen0, seen8, seen24); end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick();
         if (m_v == 20 && m_h == 10) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midreset_wait: got none want (20,10)"); end
      #2;
      nrst = 1'b0;
      #1;
      checks++; if (readoutAddr !== 8'd0) begin errors++; $display("FAIL midreset_addr: got %0d want 0", readoutAddr); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL midreset_active: got %b want 0", active); end
      checks++; if (cellX !== 2'd0 || cellY !== 3'd0) begin errors++; $display("FAIL midreset_cell: got %0d/%0d want 0/0", cellX, cellY); end
      checks++; if (nVis !== 1'b1) begin errors++; $display("FAIL midreset_nvis: got %b want 1", nVis); end
      checks++; if (hSync !== 1'b0 || vSync !== 1'b1) begin errors++; $display("FAIL midreset_sync: got %b%b want 01", hSync, vSync); end
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      startAddr = 8'd33;
      model_reset();
      for (int i = 0; i < 300; i++) begin
         tick();
         checks++; if (readoutAddr !== m_addr) begin errors++; $display("FAIL post_addr k=%0d: got %0d want %0d", m_k, readoutAddr, m_addr); end
         checks++; if (frameStart !== e_fs) begin errors++; $display("FAIL post_framestart k=%0d: got %b want %b", m_k, frameStart, e_fs); end
         checks++; if (active !== e_active) begin errors++; $display("FAIL post_active k=%0d: got %b want %b", m_k, active, e_active); end
         checks++; if (cellX !== e_cx) begin errors++; $display("FAIL post_cellx k=%0d: got %0d want %0d", m_k, cellX, e_cx); end
         checks++; if (hSync !== e_hs || vSync !== e_vs || nVis !== e_nv) begin
            errors++; $display("FAIL post_delayed k=%0d: got %b%b%b want %b%b%b", m_k, hSync, vSync, nVis, e_hs, e_vs, e_nv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_random_frames();
      test_sync_counts();
      test_scroll_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
